// File: rtl/result_bank_pkg.sv
// Shared types and default sizing for the result bank and its drain engine.
package result_bank_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 10;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} drain_state_e;
endpackage

// File: rtl/result_bank_drain.sv
// Drain engine: scans the bank in ascending order, one entry per cycle,
// and presents each valid entry as a registered valid/ready beat.
module result_bank_drain
  import result_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          clear_data,
  input  logic                          drain_start,
  input  logic                          stream_ready,
  input  logic [DEPTH-1:0][DATA_W-1:0]  bank_data,
  input  logic [DEPTH-1:0]              bank_valid,
  output logic [DEPTH-1:0]              load_map,
  output logic                          drain_busy,
  output logic                          drain_done,
  output logic [DATA_W-1:0]             stream_data,
  output logic [SEL_W-1:0]              stream_idx,
  output logic                          stream_valid
);
  localparam int IW = SEL_W + 1;
  localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);

  drain_state_e       state_q;
  logic [IW-1:0]      idx_q;
  logic [DATA_W-1:0]  sdata_q;
  logic [SEL_W-1:0]   sidx_q;
  logic               svalid_q;

  logic               slot_free, scan_live, cur_vld;
  logic [DATA_W-1:0]  cur_data;

  assign slot_free = !svalid_q || stream_ready;
  assign scan_live = (state_q == STREAM) && slot_free && (idx_q < DEPTH_I);

  // load_map tells the bank which entry is consumed this cycle
  always_comb begin
    cur_data = '0;
    cur_vld  = 1'b0;
    load_map = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx_q == IW'(i)) begin
        cur_data    = bank_data[i];
        cur_vld     = bank_valid[i];
        load_map[i] = scan_live && bank_valid[i];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sdata_q  <= '0;
      sidx_q   <= '0;
      svalid_q <= 1'b0;
    end else if (clear_data) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sdata_q  <= '0;
      sidx_q   <= '0;
      svalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (drain_start) begin
            state_q <= STREAM;
            idx_q   <= '0;
          end
        end
        STREAM: begin
          if (slot_free) begin
            if (idx_q < DEPTH_I) begin
              idx_q <= idx_q + 1'b1;
              if (cur_vld) begin
                sdata_q  <= cur_data;
                sidx_q   <= idx_q[SEL_W-1:0];
                svalid_q <= 1'b1;
              end else begin
                svalid_q <= 1'b0;
              end
            end else begin
              svalid_q <= 1'b0;
              state_q  <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drain_busy   = (state_q == STREAM);
  assign drain_done   = (state_q == DONE);
  assign stream_data  = sdata_q;
  assign stream_idx   = sidx_q;
  assign stream_valid = svalid_q;
endmodule

// File: rtl/result_bank.sv
// DEPTH x DATA_W result bank with per-entry valid flags, random-access read
// and an in-order drain port that consumes entries as they are streamed out.
module result_bank
  import result_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              w_enable,
  input  logic              clear_data,
  input  logic [SEL_W-1:0]  out_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DEPTH-1:0]  valid_map,
  output logic              full,
  output logic              err_addr,
  input  logic              drain_start,
  output logic              drain_busy,
  output logic              drain_done,
  output logic [DATA_W-1:0] stream_data,
  output logic [SEL_W-1:0]  stream_idx,
  output logic              stream_valid,
  input  logic              stream_ready
);
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             valid_q;
  logic                         err_q;
  logic [DEPTH-1:0]             wr_hit, load_map;
  logic                         in_range;

  always_comb begin
    wr_hit   = '0;
    in_range = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_sel == SEL_W'(i)) begin
        wr_hit[i] = w_enable;
        in_range  = 1'b1;
      end
    end
  end

  // A write and a drain load of the same entry: the write keeps it valid
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_q  <= '0;
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= w_enable && !in_range;
      if (clear_data) begin
        data_q  <= '0;
        valid_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_hit[i]) begin
            data_q[i]  <= in_data;
            valid_q[i] <= 1'b1;
          end else if (load_map[i]) begin
            valid_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (out_sel == SEL_W'(i)) begin
        out_data  = data_q[i];
        out_valid = valid_q[i];
      end
    end
  end

  assign valid_map = valid_q;
  assign full      = &valid_q;
  assign err_addr  = err_q;

  result_bank_drain #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_drain (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear_data   (clear_data),
    .drain_start  (drain_start),
    .stream_ready (stream_ready),
    .bank_data    (data_q),
    .bank_valid   (valid_q),
    .load_map     (load_map),
    .drain_busy   (drain_busy),
    .drain_done   (drain_done),
    .stream_data  (stream_data),
    .stream_idx   (stream_idx),
    .stream_valid (stream_valid)
  );
endmodule

// File: tb/tb_result_bank.sv
// Directed bench for result_bank: writes, reads, drain timing, backpressure,
// write/load collision and clear during drain.
module tb_result_bank;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10;
  localparam int SEL_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              n_rst;
  logic [SEL_W-1:0]  in_sel, out_sel, stream_idx;
  logic [DATA_W-1:0] in_data, out_data, stream_data;
  logic              w_enable, clear_data, out_valid, full, err_addr;
  logic [DEPTH-1:0]  valid_map;
  logic              drain_start, drain_busy, drain_done, stream_valid, stream_ready;

  int checks = 0;
  int errors = 0;
  int dones;
  int busies;

  always #5 clk = ~clk;

  result_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .in_sel(in_sel), .in_data(in_data),
    .w_enable(w_enable), .clear_data(clear_data), .out_sel(out_sel),
    .out_data(out_data), .out_valid(out_valid), .valid_map(valid_map),
    .full(full), .err_addr(err_addr), .drain_start(drain_start),
    .drain_busy(drain_busy), .drain_done(drain_done),
    .stream_data(stream_data), .stream_idx(stream_idx),
    .stream_valid(stream_valid), .stream_ready(stream_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [DATA_W-1:0] d);
    w_enable = 1'b1;
    in_sel   = SEL_W'(idx);
    in_data  = d;
    step();
    w_enable = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) wr(i, 32'h100 + 32'(i));
  endtask

  initial begin
    n_rst = 1'b0; in_sel = '0; in_data = '0; w_enable = 1'b0; clear_data = 1'b0;
    out_sel = '0; drain_start = 1'b0; stream_ready = 1'b0;
    #22;
    chk("rst_valid_map", 64'(valid_map), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_stream_valid", 64'(stream_valid), 64'h0);
    chk("rst_busy_done", 64'({drain_busy, drain_done, err_addr, full}), 64'h0);
    chk("rst_stream_regs", 64'({stream_data, stream_idx}), 64'h0);
    n_rst = 1'b1;
    step();

    // basic writes and random-access read
    wr(0, 32'h1);
    wr(9, 32'h5);
    out_sel = 4'd0; #1;
    chk("rd0_data", 64'(out_data), 64'h1);
    chk("rd0_valid", 64'(out_valid), 64'h1);
    out_sel = 4'd9; #1;
    chk("rd9_data", 64'(out_data), 64'h5);
    chk("vmap_0_9", 64'(valid_map), 64'h201);

    // disabled write, then out-of-range write
    in_sel = 4'd0; in_data = 32'h3; w_enable = 1'b0;
    step();
    out_sel = 4'd0; #1;
    chk("no_we_keep", 64'(out_data), 64'h1);
    chk("no_err_yet", 64'(err_addr), 64'h0);
    wr(12, 32'hDEAD);
    chk("err_pulse", 64'(err_addr), 64'h1);
    chk("err_vmap", 64'(valid_map), 64'h201);
    step();
    chk("err_clear", 64'(err_addr), 64'h0);
    out_sel = 4'd12; #1;
    chk("oob_rd_data", 64'(out_data), 64'h0);
    chk("oob_rd_valid", 64'(out_valid), 64'h0);

    // full bank drain, ready held high
    fill();
    chk("full", 64'(full), 64'h1);
    stream_ready = 1'b1;
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    chk("d1_busy_k", 64'(drain_busy), 64'h1);
    chk("d1_no_beat_k", 64'(stream_valid), 64'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("d1_beat", 64'({stream_valid, stream_idx, stream_data}),
          64'({1'b1, SEL_W'(i), 32'h100 + 32'(i)}));
    end
    step();
    chk("d1_done", 64'({drain_done, drain_busy, stream_valid}), 64'b100);
    chk("d1_vmap", 64'(valid_map), 64'h0);
    step();
    chk("d1_done_once", 64'(drain_done), 64'h0);

    // sparse bank with backpressure on the first beat
    wr(2, 32'h22);
    wr(7, 32'h77);
    stream_ready = 1'b0;
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    step(); step(); step();
    chk("d2_beat2", 64'({stream_valid, stream_idx, stream_data}), 64'({1'b1, 4'd2, 32'h22}));
    step();
    chk("d2_hold1", 64'({stream_valid, stream_idx, stream_data}), 64'({1'b1, 4'd2, 32'h22}));
    step();
    chk("d2_hold2", 64'({stream_valid, stream_idx, stream_data}), 64'({1'b1, 4'd2, 32'h22}));
    stream_ready = 1'b1;
    step();
    for (int n = 0; n < 20 && !stream_valid; n++) step();
    chk("d2_beat7", 64'({stream_valid, stream_idx, stream_data}), 64'({1'b1, 4'd7, 32'h77}));
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (drain_done) dones++;
    end
    chk("d2_one_done", 64'(dones), 64'h1);
    chk("d2_vmap", 64'(valid_map), 64'h0);

    // write to idx 4 in the same cycle it is loaded
    fill();
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    w_enable = 1'b1; in_sel = 4'd4; in_data = 32'hBEEF;
    step();
    w_enable = 1'b0;
    chk("d3_beat4_old", 64'({stream_valid, stream_idx, stream_data}), 64'({1'b1, 4'd4, 32'h104}));
    out_sel = 4'd4; #1;
    chk("d3_new_data", 64'({out_valid, out_data}), 64'({1'b1, 32'hBEEF}));
    for (int n = 0; n < 15 && !drain_done; n++) step();
    chk("d3_done", 64'(drain_done), 64'h1);
    chk("d3_vmap", 64'(valid_map), 64'h010);

    // clear mid-drain with a write and drain_start in the same cycle
    step();
    fill();
    drain_start = 1'b1;
    step();
    drain_start = 1'b0;
    step(); step(); step();
    chk("d4_beat2", 64'({stream_valid, stream_idx}), 64'({1'b1, 4'd2}));
    clear_data = 1'b1; drain_start = 1'b1;
    w_enable = 1'b1; in_sel = 4'd5; in_data = 32'h55;
    step();
    clear_data = 1'b0; drain_start = 1'b0; w_enable = 1'b0;
    chk("clr_vmap", 64'(valid_map), 64'h0);
    chk("clr_stream", 64'({stream_valid, stream_idx, stream_data}), 64'h0);
    chk("clr_idle", 64'({drain_busy, drain_done}), 64'h0);
    out_sel = 4'd5; #1;
    chk("clr_wr_lost", 64'({out_valid, out_data}), 64'h0);
    dones = 0; busies = 0;
    for (int n = 0; n < 15; n++) begin
      step();
      if (drain_done) dones++;
      if (drain_busy) busies++;
    end
    chk("clr_no_done", 64'(dones), 64'h0);
    chk("clr_no_restart", 64'(busies), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_bank.md
# result_bank

Parametrised result storage for the accelerator's output path: a DEPTH x DATA_W register bank with per-entry valid flags, random-access combinational read, and a drain engine that streams every valid entry in ascending index order over a valid/ready handshake, consuming each entry as it is sent. Sits between the compute datapath, which writes results by index, and the host/output interface, which either polls single entries or drains the whole bank.

## Interface
- DATA_W, 32, width of each entry
- DEPTH, 10, number of entries (>= 2); SEL_W = $clog2(DEPTH) is derived, not overridable
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- in_sel  in  SEL_W  write index
- in_data  in  DATA_W  write data
- w_enable  in  1  write strobe
- clear_data  in  1  synchronous flush of all entries and drain engine
- out_sel  in  SEL_W  random-access read index
- out_data  out  DATA_W  entry[out_sel] data, combinational
- out_valid  out  1  valid flag of entry[out_sel], combinational
- valid_map  out  DEPTH  registered per-entry valid flags
- full  out  1  all entries valid
- err_addr  out  1  one-cycle pulse: previous-cycle write had in_sel >= DEPTH
- drain_start  in  1  begin drain (ignored unless idle)
- drain_busy  out  1  drain engine in STREAM
- drain_done  out  1  one-cycle completion pulse
- stream_data  out  DATA_W  registered beat data
- stream_idx  out  SEL_W  registered beat source index
- stream_valid  out  1  beat present
- stream_ready  in  1  consumer accepts beat

## Operation
- Reset: all data, valid_map, stream_data, stream_idx = 0; stream_valid, drain_busy, drain_done, err_addr, full = 0; FSM IDLE.
- Write: w_enable & in_sel < DEPTH stores in_data and sets valid at the edge. in_sel >= DEPTH: no state change, err_addr = 1 next cycle.
- Read: out_sel >= DEPTH gives out_data = 0, out_valid = 0.
- clear_data: at the edge, all data and valid = 0, stream regs cleared, FSM -> IDLE; highest priority over write, drain_start and handshake in the same cycle; aborted drain gives no drain_done.
- FSM IDLE: drain_start -> STREAM, scan index = 0.
- STREAM: load slot free when stream_valid = 0 or (stream_valid & stream_ready). With slot free and scan index < DEPTH: if entry valid, load stream_data/stream_idx, set stream_valid, clear entry valid; index increments by one either way (one entry examined per cycle). Slot not free: index holds.
- STREAM -> DONE when scan index = DEPTH and slot free (final beat accepted or none pending). DONE: drain_done = 1 for one cycle -> IDLE.
- drain_start while STREAM/DONE ignored. Writes permitted during drain.
- Write and load of the same entry in one cycle: beat carries old data; write wins, entry ends valid with new data. Writes to an already-scanned index stay in the bank.
- Beat stable (data, idx) while stream_valid & !stream_ready, except clear_data.

## Timing
- Write visible on out_data/out_valid/valid_map the cycle after the write edge.
- drain_start sampled at edge k; drain_busy from k; first possible stream_valid after edge k+1.
- Full bank, stream_ready held 1: beats in cycles k+1..k+DEPTH, one per cycle; drain_done high in cycle k+DEPTH+1; drain_busy low the same cycle.
- Empty bank: drain_done high in cycle k+DEPTH+1, no beats.
- full combinational from valid_map.

## Structure
- result_bank_pkg: drain state enum (IDLE, STREAM, DONE), default DATA_W/DEPTH constants.
- Sub-module result_bank_drain: FSM, scan counter, output stage; bank arrays and write/clear logic in the top.

## Test plan
- Reset then write idx 0 = 0x0001, idx 9 = 0x0005 -> out_data matches with out_valid = 1; valid_map = 10'b10_0000_0001.
- Write 0x0003 with w_enable = 0; then write in_sel = 12 -> idx 0 still holds prior value; err_addr pulses once, valid_map unchanged.
- Fill all 10 (idx i = 0x100+i), full = 1, drain with ready = 1 -> beats 0x100..0x109, idx 0..9, consecutive cycles; drain_done in cycle 11 after start; valid_map = 0.
- Valid only idx 2, 7; ready low 3 cycles on first beat -> beat (2, data) held stable; then idx 7 beat; one drain_done.
- Write idx 4 = 0xBEEF in the cycle idx 4 (old 0x104) is loaded -> beat carries 0x104; afterwards out_sel = 4 gives 0xBEEF, valid.
- clear_data mid-drain with write in same cycle -> all zero, stream_valid = 0 next cycle, FSM IDLE, no drain_done; drain_start together with clear_data ignored.
